// File: rtl/rnn_timestep_sequencer_if.sv
// Handshake and datapath bus bundle between the RNN timestep sequencer (slave)
// and its surroundings: sample source, matrix-vector datapaths, bias store (master).
interface rnn_timestep_sequencer_if #(
  parameter int INPUT_SIZE  = 20,
  parameter int HIDDEN_SIZE = 20,
  parameter int BW          = 32,
  parameter int LEN_W       = 16
);
  logic                        start;
  logic [LEN_W-1:0]            seq_len;
  logic                        x_valid;
  logic                        x_ready;
  logic [INPUT_SIZE*BW-1:0]    x_bus;
  logic [INPUT_SIZE*BW-1:0]    x_to_dp;
  logic [HIDDEN_SIZE*BW-1:0]   h_to_dp;
  logic [HIDDEN_SIZE*BW-1:0]   wx_bus;
  logic [HIDDEN_SIZE*BW-1:0]   wh_bus;
  logic [HIDDEN_SIZE*BW-1:0]   b_bus;
  logic                        step_valid;
  logic [LEN_W-1:0]            step_idx;
  logic                        busy;
  logic                        done;

  modport master (
    output start, seq_len, x_valid, x_bus, wx_bus, wh_bus, b_bus,
    input  x_ready, x_to_dp, h_to_dp, step_valid, step_idx, busy, done
  );

  modport slave (
    input  start, seq_len, x_valid, x_bus, wx_bus, wh_bus, b_bus,
    output x_ready, x_to_dp, h_to_dp, step_valid, step_idx, busy, done
  );
endinterface

// File: rtl/rnn_timestep_sequencer.sv
// Steps one Elman RNN layer through a sequence: latch x, let the external
// W_ih*x / W_hh*h datapaths settle, then register h = hardtanh(wx + wh + b).
module rnn_timestep_sequencer #(
  parameter int INPUT_SIZE    = 20,
  parameter int HIDDEN_SIZE   = 20,
  parameter int BW            = 32,
  parameter int FRAC_BITS     = 15,
  parameter int SETTLE_CYCLES = 2,
  parameter int LEN_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rnn_timestep_sequencer_if.slave  io
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic signed [BW+1:0] POS_ONE = (BW+2)'(1) <<< FRAC_BITS;
  localparam logic signed [BW+1:0] NEG_ONE = -POS_ONE;

  typedef enum logic [1:0] {IDLE, WAIT_X, SETTLE, DONE} state_e;

  state_e                    state_q, state_d;
  logic [INPUT_SIZE*BW-1:0]  xToDp_q, xToDp_d;
  logic [HIDDEN_SIZE*BW-1:0] hToDp_q, hToDp_d;
  logic [LEN_W-1:0]          stepCnt_q, stepCnt_d;
  logic [LEN_W-1:0]          seqLen_q, seqLen_d;
  logic [SW-1:0]             settleCnt_q, settleCnt_d;
  logic                      stepValid_q, stepValid_d;
  logic [LEN_W-1:0]          stepIdx_q, stepIdx_d;

  logic [HIDDEN_SIZE*BW-1:0] hNext;
  logic [LEN_W-1:0]          stepInc;

  assign stepInc = stepCnt_q + 1'b1;

  // Three BW-bit terms fit exactly in BW+2 bits, so the clamp alone prevents wrap.
  for (genvar g = 0; g < HIDDEN_SIZE; g++) begin : gClip
    localparam int LSB = (HIDDEN_SIZE - 1 - g) * BW;
    logic signed [BW+1:0] sum;
    assign sum = $signed({{2{io.wx_bus[LSB+BW-1]}}, io.wx_bus[LSB +: BW]})
               + $signed({{2{io.wh_bus[LSB+BW-1]}}, io.wh_bus[LSB +: BW]})
               + $signed({{2{io.b_bus[LSB+BW-1]}},  io.b_bus[LSB +: BW]});
    assign hNext[LSB +: BW] = (sum > POS_ONE) ? POS_ONE[BW-1:0] :
                              (sum < NEG_ONE) ? NEG_ONE[BW-1:0] : sum[BW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    xToDp_d     = xToDp_q;
    hToDp_d     = hToDp_q;
    stepCnt_d   = stepCnt_q;
    seqLen_d    = seqLen_q;
    settleCnt_d = settleCnt_q;
    stepValid_d = 1'b0;
    stepIdx_d   = stepIdx_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          hToDp_d   = '0;
          stepCnt_d = '0;
          if (io.seq_len == '0) begin
            state_d = DONE;
          end else begin
            seqLen_d = io.seq_len;
            state_d  = WAIT_X;
          end
        end
      end
      WAIT_X: begin
        if (io.x_valid) begin
          xToDp_d     = io.x_bus;
          settleCnt_d = '0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (settleCnt_q == SETTLE_LAST) begin
          hToDp_d     = hNext;
          stepCnt_d   = stepInc;
          stepValid_d = 1'b1;
          stepIdx_d   = stepCnt_q;
          state_d     = (stepInc == seqLen_q) ? DONE : WAIT_X;
        end else begin
          settleCnt_d = settleCnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xToDp_q     <= '0;
      hToDp_q     <= '0;
      stepCnt_q   <= '0;
      seqLen_q    <= '0;
      settleCnt_q <= '0;
      stepValid_q <= 1'b0;
      stepIdx_q   <= '0;
    end else begin
      state_q     <= state_d;
      xToDp_q     <= xToDp_d;
      hToDp_q     <= hToDp_d;
      stepCnt_q   <= stepCnt_d;
      seqLen_q    <= seqLen_d;
      settleCnt_q <= settleCnt_d;
      stepValid_q <= stepValid_d;
      stepIdx_q   <= stepIdx_d;
    end
  end

  assign io.x_ready    = (state_q == WAIT_X);
  assign io.busy       = (state_q != IDLE);
  assign io.done       = (state_q == DONE);
  assign io.x_to_dp    = xToDp_q;
  assign io.h_to_dp    = hToDp_q;
  assign io.step_valid = stepValid_q;
  assign io.step_idx   = stepIdx_q;

endmodule
